// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive GCD unit.
package gcd_pkg;

    // Operand/result width when the instantiating module does not override it.
    localparam int DEFAULT_DATA_WIDTH = 4;

    // IDLE: accepting a pair, CALC: one compare/subtract step per cycle,
    // DONE: result presented until downstream takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_t;

endpackage

// File: rtl/gcd_unit.sv
// Subtractive GCD engine with valid/ready handshakes on both sides.
//
// Handshake semantics: a transfer happens on a rising clk_i edge where both
// valid and ready are high. in_ready_o is high only in IDLE and out_valid_o
// only in DONE, both decoded straight from the state register, so neither
// depends combinationally on the opposite side's valid/ready.
//
// Optional feature: define GCD_ITER_CNT_EN to add the iter_o port, which
// reports how many CALC cycles the current/last job took.
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] gcd_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [DATA_WIDTH-1:0] iter_o
`endif
);

    gcd_state_t            state, state_next;
    logic [DATA_WIDTH-1:0] a_reg, a_next;
    logic [DATA_WIDTH-1:0] b_reg, b_next;
    logic [DATA_WIDTH-1:0] result, result_next;
    logic                  accept;
    logic                  finish;

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);
    assign gcd_o       = result;
    assign accept      = in_valid_i & in_ready_o;

    // A zero operand or equal operands means the other/either value is the GCD.
    assign finish = (a_reg == '0) || (b_reg == '0) || (a_reg == b_reg);

    // State and datapath registers; reset discards any job in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            result <= '0;
        end else begin
            state  <= state_next;
            a_reg  <= a_next;
            b_reg  <= b_next;
            result <= result_next;
        end
    end

    // Next-state and datapath: load on accept, subtract smaller from larger in CALC.
    always_comb begin
        state_next  = state;
        a_next      = a_reg;
        b_next      = b_reg;
        result_next = result;
        case (state)
            IDLE: begin
                if (accept) begin
                    a_next     = a_i;
                    b_next     = b_i;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (finish) begin
                    result_next = (a_reg == '0) ? b_reg : a_reg;
                    state_next  = DONE;
                end else if (a_reg > b_reg) begin
                    a_next = a_reg - b_reg;
                end else begin
                    b_next = b_reg - a_reg;
                end
            end
            DONE: begin
                // Consumption returns to IDLE; the accept can only happen a cycle later.
                if (out_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef GCD_ITER_CNT_EN
    logic [DATA_WIDTH-1:0] iter_cnt;

    // CALC-cycle counter: cleared on accept, counts each CALC cycle, holds otherwise.
    // A job never exceeds 2^DATA_WIDTH-1 CALC cycles, so it cannot wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            iter_cnt <= '0;
        end else if (accept) begin
            iter_cnt <= '0;
        end else if (state == CALC) begin
            iter_cnt <= iter_cnt + DATA_WIDTH'(1);
        end
    end

    assign iter_o = iter_cnt;
`endif

endmodule

// File: tb/tb_gcd_unit.sv
// Directed bench for gcd_unit at DATA_WIDTH=4 with hand-computed results.
module tb_gcd_unit;

    localparam int W = 4;

    logic         clk_i;
    logic         rst_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] gcd_o;
    logic         out_valid_o;
    logic         out_ready_i;
`ifdef GCD_ITER_CNT_EN
    logic [W-1:0] iter_o;
`endif

    int pass_cnt;
    int total_cnt;
    int cycles;

    gcd_unit #(.DATA_WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .gcd_o       (gcd_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
`ifdef GCD_ITER_CNT_EN
        ,
        .iter_o      (iter_o)
`endif
    );

    // Clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("check %s wrong: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a pair for exactly one edge (unit is in IDLE, so it is accepted).
    task automatic send_pair(input int a, input int b);
        a_i        = W'(a);
        b_i        = W'(b);
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid_o is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (out_valid_o !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic check_iter(input string tag, input int exp);
`ifdef GCD_ITER_CNT_EN
        check(tag, int'(iter_o), exp);
`endif
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        rst_i       = 1'b1;
        a_i         = '0;
        b_i         = '0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;

        // Reset state
        check("rst_in_ready", int'(in_ready_o), 1);
        check("rst_out_valid", int'(out_valid_o), 0);
        check("rst_gcd", int'(gcd_o), 0);
        check_iter("rst_iter", 0);

        // gcd(12,8)=4, 3 cycles; operands change mid-job and must not matter
        send_pair(12, 8);
        check("12_8_in_ready_busy", int'(in_ready_o), 0);
        check("12_8_no_valid_yet", int'(out_valid_o), 0);
        a_i = 4'd3;
        b_i = 4'd7;
        wait_done(cycles);
        check("12_8_latency", cycles, 3);
        check("12_8_gcd", int'(gcd_o), 4);
        check_iter("12_8_iter", 3);
        tick();
        check("12_8_consumed", int'(out_valid_o), 0);
        check("12_8_idle", int'(in_ready_o), 1);

        // gcd(15,1)=1 after 15 CALC cycles
        send_pair(15, 1);
        wait_done(cycles);
        check("15_1_latency", cycles, 15);
        check("15_1_gcd", int'(gcd_o), 1);
        check_iter("15_1_iter", 15);
        tick();

        // Zero-operand edge cases, one CALC cycle each
        send_pair(0, 9);
        wait_done(cycles);
        check("0_9_latency", cycles, 1);
        check("0_9_gcd", int'(gcd_o), 9);
        check_iter("0_9_iter", 1);
        tick();
        send_pair(9, 0);
        wait_done(cycles);
        check("9_0_latency", cycles, 1);
        check("9_0_gcd", int'(gcd_o), 9);
        tick();
        send_pair(0, 0);
        wait_done(cycles);
        check("0_0_latency", cycles, 1);
        check("0_0_gcd", int'(gcd_o), 0);
        tick();

        // gcd(6,4)=2 held under backpressure; a new pair is offered and ignored
        out_ready_i = 1'b0;
        send_pair(6, 4);
        wait_done(cycles);
        check("6_4_latency", cycles, 3);
        a_i        = 4'd9;
        b_i        = 4'd6;
        in_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("6_4_hold_gcd", int'(gcd_o), 2);
            check("6_4_hold_valid", int'(out_valid_o), 1);
            check("6_4_hold_in_ready", int'(in_ready_o), 0);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        tick();
        check("6_4_released", int'(out_valid_o), 0);
        check("6_4_idle", int'(in_ready_o), 1);
        check("6_4_gcd_kept", int'(gcd_o), 2);
        tick();
        check("6_4_stays_idle", int'(in_ready_o), 1);

        // Reset during CALC of (15,1) discards the job
        send_pair(15, 1);
        for (int i = 0; i < 4; i++) begin
            check("rst_mid_no_valid", int'(out_valid_o), 0);
            tick();
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rst_mid_idle", int'(in_ready_o), 1);
        check("rst_mid_out_valid", int'(out_valid_o), 0);
        check("rst_mid_gcd", int'(gcd_o), 0);
        check_iter("rst_mid_iter", 0);
        tick();
        check("rst_mid_still_idle", int'(out_valid_o), 0);
        send_pair(9, 6);
        wait_done(cycles);
        check("9_6_latency", cycles, 3);
        check("9_6_gcd", int'(gcd_o), 3);
        tick();

        // Back-to-back FIFO-fed pairs with in_valid_i held high
        a_i        = 4'd8;
        b_i        = 4'd4;
        in_valid_i = 1'b1;
        tick();
        a_i = 4'd7;
        b_i = 4'd5;
        wait_done(cycles);
        check("b2b_8_4_latency", cycles, 2);
        check("b2b_8_4_gcd", int'(gcd_o), 4);
        tick();
        check("b2b_bubble_idle", int'(in_ready_o), 1);
        check("b2b_bubble_no_valid", int'(out_valid_o), 0);
        tick();
        in_valid_i = 1'b0;
        check("b2b_7_5_accepted", int'(in_ready_o), 0);
        wait_done(cycles);
        check("b2b_7_5_latency", cycles, 5);
        check("b2b_7_5_gcd", int'(gcd_o), 1);
        check_iter("b2b_7_5_iter", 5);
        tick();
        check("b2b_end_idle", int'(in_ready_o), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/gcd_unit.md
GCD_UNIT -- requirements
Module: gcd_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, operand and result width in bits.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port a_i  input  DATA_WIDTH  first operand, fed from upstream FIFO.
REQ-005 SHALL have port b_i  input  DATA_WIDTH  second operand.
REQ-006 SHALL have port in_valid_i  input  1  operand pair valid.
REQ-007 SHALL have port in_ready_o  output  1  unit can accept a pair.
REQ-008 SHALL have port gcd_o  output  DATA_WIDTH  result.
REQ-009 SHALL have port out_valid_o  output  1  result valid.
REQ-010 SHALL have port out_ready_i  input  1  downstream accepts result.
REQ-011 SHALL have port iter_o  output  DATA_WIDTH  CALC-cycle count, present only with GCD_ITER_CNT_EN.

Function
REQ-012 SHALL implement FSM with states IDLE, CALC, DONE.
REQ-013 in_ready_o SHALL be 1 only in IDLE; out_valid_o SHALL be 1 only in DONE (both registered-state decodes).
REQ-014 Input handshake = in_valid_i & in_ready_o at rising edge: SHALL load A<=a_i, B<=b_i, go CALC.
REQ-015 Each CALC cycle: if A==0 or B==0 or A==B, result<= (A==0 ? B : A), go DONE; else if A>B then A<=A-B, else B<=B-A.
REQ-016 Subtraction SHALL be unsigned DATA_WIDTH-bit; never underflows since larger minus smaller.
REQ-017 Latency: out_valid_o SHALL rise (k+1) cycles after accept edge, k = number of subtractions; gcd(12,8) -> 3 cycles.
REQ-018 Edge cases: gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0, each in 1 CALC cycle.
REQ-019 In DONE, gcd_o SHALL stay stable until out_valid_o & out_ready_i, then go IDLE next cycle.
REQ-020 in_valid_i while not in IDLE SHALL be ignored; a_i/b_i SHALL not affect running computation.
REQ-021 No new pair SHALL be accepted in the cycle a result is consumed (one-cycle IDLE bubble between jobs).
REQ-022 out_ready_i held high before DONE SHALL cause result consumption in the first DONE cycle.

Reset
REQ-023 rst_i high at an edge SHALL force IDLE, A=B=0, gcd_o=0, out_valid_o=0, iter_o=0; in_ready_o=1 on first cycle after reset.
REQ-024 rst_i SHALL take priority over all handshakes; reset mid-CALC or mid-DONE SHALL discard the job with no output.

Configuration
REQ-025 Macro GCD_ITER_CNT_EN defined: iter_o SHALL exist, clear on accept, increment per CALC cycle, hold in DONE (max 2^DATA_WIDTH-1, no overflow possible).
REQ-026 Macro undefined: iter_o port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package gcd_pkg SHALL hold state enum typedef (IDLE, CALC, DONE) and default DATA_WIDTH constant.
REQ-028 Single module, no sub-module; compare/subtract datapath inline.

Verification (DATA_WIDTH=4)
REQ-029 Pair (12,8), out_ready_i=1 -> gcd_o=4, out_valid_o high 3 cycles after accept, iter_o=3.
REQ-030 Pair (15,1) -> gcd_o=1 after 15 CALC cycles, iter_o=15.
REQ-031 Pairs (0,9), (9,0), (0,0) -> gcd_o=9, 9, 0, each after 1 CALC cycle.
REQ-032 (6,4) with out_ready_i low 5 cycles in DONE -> gcd_o=2 held stable, in_ready_o=0, later pair ignored until consumed.
REQ-033 rst_i pulsed during CALC of (15,1) -> no out_valid_o, IDLE next cycle, then (9,6) -> gcd_o=3.
REQ-034 Back-to-back FIFO-fed pairs (8,4),(7,5) with in_valid_i held high -> results 4 then 1, in order, one IDLE cycle between.
